data_bus_slice: RTL and testbench
=================================

# data_bus_slice

Registered request/response slice on the Ibex data bus, placed between the core's data port and the peripheral interconnect (the data bus arbiter and the slave mux). It breaks the combinational path from core request through address decode to slave grant, and the path from slave response back to the core. It allows one outstanding transaction. It returns a bus error to the core when a slave fails to grant or respond within a bounded number of cycles.

## Interface
- TIMEOUT, 16: cycles allowed in each of REQ and RSP before the transaction is aborted; legal range 2..255.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s_req  in  1  core request.
- s_gnt  out  1  request accepted; combinational, equals s_req & (state==IDLE).
- s_addr  in  32  byte address.
- s_we  in  1  write enable.
- s_be  in  4  byte enables.
- s_wdata  in  32  write data.
- s_rvalid  out  1  response valid, registered, one-cycle pulse.
- s_rdata  out  32  read data, registered.
- s_err  out  1  response error, registered; qualified by s_rvalid.
- m_req  out  1  request to interconnect, registered.
- m_gnt  in  1  interconnect grant.
- m_addr, m_we, m_be, m_wdata  out  32/1/4/32  registered copies of the accepted request.
- m_rvalid  in  1  interconnect response valid.
- m_rdata  in  32  interconnect read data.
- m_err  in  1  interconnect error.

## Operation
- FSM states:
  - IDLE: s_gnt = s_req. On s_req, capture addr/we/be/wdata and go to REQ.
  - REQ: m_req = 1 and the payload is held stable. On m_gnt, go to RSP. On timeout: s_rvalid=1, s_err=1, s_rdata=0 next cycle; m_req drops; go to IDLE.
  - RSP: m_req = 0. On m_rvalid, register m_rdata/m_err into s_rdata/s_err, pulse s_rvalid next cycle, go to IDLE. On timeout: error response as in REQ; go to IDLE.
- Timeout counter:
  - Width 8. Cleared on every entry to REQ or RSP, and increments each cycle spent in either state.
  - Timeout fires in the cycle the counter equals TIMEOUT-1 and the exiting event (m_gnt or m_rvalid) is absent.
  - If the exiting event occurs in that same cycle, the event wins and no error is produced.
- m_rvalid is ignored outside RSP, so a late response after an abort is dropped.
- s_rdata holds its last value between pulses; it is 0 on error responses.
- A write response passes m_rdata through unmodified; the core ignores it.
- s_gnt for a new request may coincide with s_rvalid of the previous one. This is legal per the Ibex protocol.

## Timing
- Reset values: state IDLE, counter 0, m_req 0, m_addr/m_wdata 0, m_we 0, m_be 0, s_rvalid 0, s_err 0, s_rdata 0.
- rst asserted mid-transaction: return to IDLE next edge. No response is issued for the abandoned transaction.
- Nominal path, with the slave granting immediately and responding one cycle after grant:
  - Cycle 0: s_req=1, s_gnt=1.
  - Cycle 1: m_req=1, m_gnt=1.
  - Cycle 2: m_rvalid=1.
  - Cycle 3: s_rvalid=1.
  - Grant-to-rvalid at the core is 3 cycles, against 1 without the slice.
- Back-to-back throughput: one transaction per 3 cycles, because a new s_gnt is possible in the cycle of s_rvalid.
- Worst-case abort latency: TIMEOUT cycles in REQ plus 1 cycle to s_rvalid; the same bound applies to RSP.

## Test plan
- Read, immediate slave: s_req addr=0x0001_0004 at cycle 0. Required: s_gnt at 0; m_req and m_addr=0x0001_0004 at 1. The slave grants at 1 and returns m_rdata=0xDEAD_BEEF at 2. Required: s_rvalid=1, s_rdata=0xDEAD_BEEF, s_err=0 at 3.
- Write with a stalled grant: we=1, be=4'b0011, wdata=0x1234_5678, m_gnt held low 5 cycles. Required: m_req and payload stable for all 6 cycles; exactly one s_rvalid, 2 cycles after m_gnt.
- Grant timeout with TIMEOUT=4 and m_gnt never asserted. Required: m_req high for 4 cycles, then low; s_rvalid=1, s_err=1, s_rdata=0 in the following cycle; state IDLE.
- Response timeout plus late rvalid: grant given, m_rvalid withheld until 2 cycles after the abort. Required: one error response only, and the late m_rvalid produces no s_rvalid.
- Boundary and back-to-back: m_rvalid arrives exactly at counter==TIMEOUT-1. Required: normal response with s_err=0. Then a second s_req in the s_rvalid cycle. Required: s_gnt=1 in that cycle.
- Reset mid-RSP: rst pulsed while waiting for m_rvalid. Required: all outputs at reset values next cycle, no s_rvalid, and a subsequent transaction completes normally.

Source files
------------

// File: rtl/data_bus_slice.sv
// Registered request/response slice for the Ibex data bus.
// One outstanding transaction, with grant/response timeout abort.
module data_bus_slice #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_req,
  output logic        s_gnt,
  input  logic [31:0] s_addr,
  input  logic        s_we,
  input  logic [3:0]  s_be,
  input  logic [31:0] s_wdata,
  output logic        s_rvalid,
  output logic [31:0] s_rdata,
  output logic        s_err,
  output logic        m_req,
  input  logic        m_gnt,
  output logic [31:0] m_addr,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic        m_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_e;

  localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        m_req_q, m_req_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic        m_we_q, m_we_d;
  logic [3:0]  m_be_q, m_be_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        expired;

  assign expired = (cnt_q == CntMax);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 8'd1;
    m_addr_d  = m_addr_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_wdata_d = m_wdata_q;
    rvalid_d  = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (s_req) begin
          state_d   = REQ;
          m_addr_d  = s_addr;
          m_we_d    = s_we;
          m_be_d    = s_be;
          m_wdata_d = s_wdata;
        end
      end
      REQ: begin
        if (m_gnt) begin
          state_d = RSP;
          cnt_d   = 8'd0;
        end else if (expired) begin
          state_d  = IDLE;
          cnt_d    = 8'd0;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          rdata_d  = 32'd0;
        end
      end
      RSP: begin
        // the response event wins over a same-cycle timeout
        if (m_rvalid) begin
          state_d  = IDLE;
          cnt_d    = 8'd0;
          rvalid_d = 1'b1;
          err_d    = m_err;
          rdata_d  = m_rdata;
        end else if (expired) begin
          state_d  = IDLE;
          cnt_d    = 8'd0;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          rdata_d  = 32'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    m_req_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      m_req_q   <= 1'b0;
      m_addr_q  <= 32'd0;
      m_we_q    <= 1'b0;
      m_be_q    <= 4'd0;
      m_wdata_q <= 32'd0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_addr_q  <= m_addr_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_wdata_q <= m_wdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_gnt    = s_req & (state_q == IDLE);
  assign s_rvalid = rvalid_q;
  assign s_rdata  = rdata_q;
  assign s_err    = err_q;
  assign m_req    = m_req_q;
  assign m_addr   = m_addr_q;
  assign m_we     = m_we_q;
  assign m_be     = m_be_q;
  assign m_wdata  = m_wdata_q;

endmodule

// File: tb/tb_data_bus_slice.sv
// Testbench for data_bus_slice: directed scenarios plus randomized
// transactions checked against a per-transaction timing model.
module tb_data_bus_slice;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_req;
  logic        s_gnt;
  logic [31:0] s_addr;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_wdata;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic        s_err;
  logic        m_req;
  logic        m_gnt;
  logic [31:0] m_addr;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_bus_slice #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_gnt(s_gnt),
    .s_addr(s_addr), .s_we(s_we),
    .s_be(s_be), .s_wdata(s_wdata),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .s_err(s_err),
    .m_req(m_req), .m_gnt(m_gnt),
    .m_addr(m_addr), .m_we(m_we),
    .m_be(m_be), .m_wdata(m_wdata),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .m_err(m_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // g: cycles m_gnt is withheld in REQ (>=TO means never granted)
  // r: cycles m_rvalid is withheld in RSP (>=TO means late response)
  // chain: return in the s_rvalid cycle without advancing the clock
  task automatic run_txn(
    input string       nm,
    input int          g,
    input int          r,
    input logic        we,
    input logic [31:0] addr,
    input logic [3:0]  be,
    input logic [31:0] wdata,
    input logic [31:0] rdata,
    input logic        rerr,
    input bit          chain
  );
    int done_c, rv_c, req_last, last;
    logic        exp_err;
    logic [31:0] exp_rdata;
    if (g >= TO) begin
      done_c = TO + 1;
      req_last = TO;
      rv_c = -1;
    end else begin
      req_last = 1 + g;
      rv_c = 2 + g + r;
      done_c = (r >= TO) ? 2 + g + TO : 3 + g + r;
    end
    exp_err = (g >= TO || r >= TO) ? 1'b1 : rerr;
    exp_rdata = (g >= TO || r >= TO) ? 32'd0 : rdata;
    last = chain ? done_c : ((rv_c > done_c ? rv_c : done_c) + 1);
    s_req = 1'b1;
    s_addr = addr;
    s_we = we;
    s_be = be;
    s_wdata = wdata;
    m_gnt = 1'b0;
    m_rvalid = 1'b0;
    #1;
    checks++;
    if (s_gnt !== 1'b1) begin
      errors++;
      $display("FAIL %s s_gnt c0 got %b want 1", nm, s_gnt);
    end
    tick();
    s_req = 1'b0;
    s_addr = $urandom;
    s_wdata = $urandom;
    for (int c = 1; c <= last; c++) begin
      m_gnt = (g < TO) && (c == 1 + g);
      m_rvalid = (c == rv_c);
      m_rdata = (c == rv_c) ? rdata : $urandom;
      m_err = (c == rv_c) ? rerr : 1'($urandom);
      #1;
      checks++;
      if (m_req !== (c <= req_last)) begin
        errors++;
        $display("FAIL %s m_req c%0d got %b want %b",
                 nm, c, m_req, (c <= req_last));
      end
      if (c <= req_last) begin
        checks++;
        if (m_addr !== addr || m_we !== we ||
            m_be !== be || m_wdata !== wdata) begin
          errors++;
          $display("FAIL %s payload c%0d got %h/%b/%h/%h want %h/%b/%h/%h",
                   nm, c, m_addr, m_we, m_be, m_wdata,
                   addr, we, be, wdata);
        end
      end
      checks++;
      if (s_rvalid !== (c == done_c)) begin
        errors++;
        $display("FAIL %s s_rvalid c%0d got %b want %b",
                 nm, c, s_rvalid, (c == done_c));
      end
      if (c == done_c) begin
        checks++;
        if (s_err !== exp_err || s_rdata !== exp_rdata) begin
          errors++;
          $display("FAIL %s resp got err=%b rdata=%h want err=%b rdata=%h",
                   nm, s_err, s_rdata, exp_err, exp_rdata);
        end
      end
      if (c > done_c) begin
        checks++;
        if (s_rdata !== exp_rdata) begin
          errors++;
          $display("FAIL %s rdata hold c%0d got %h want %h",
                   nm, c, s_rdata, exp_rdata);
        end
      end
      if (!(chain && c == last)) tick();
    end
    m_gnt = 1'b0;
    m_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_req = 1'b0;
    s_addr = 32'hFFFF_FFFF;
    s_we = 1'b1;
    s_be = 4'hF;
    s_wdata = 32'hFFFF_FFFF;
    m_gnt = 1'b0;
    m_rvalid = 1'b0;
    m_rdata = 32'hA5A5_A5A5;
    m_err = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (m_req !== 1'b0 || m_addr !== 32'd0 || m_we !== 1'b0 ||
        m_be !== 4'd0 || m_wdata !== 32'd0 || s_rvalid !== 1'b0 ||
        s_err !== 1'b0 || s_rdata !== 32'd0 || s_gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got req=%b addr=%h rv=%b err=%b rd=%h",
               m_req, m_addr, s_rvalid, s_err, s_rdata);
    end
    tick();
  endtask

  task automatic test_read_immediate();
    run_txn("read_imm", 0, 0, 1'b0, 32'h0001_0004, 4'hF,
            32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
  endtask

  task automatic test_write_stall();
    run_txn("write_stall", 5, 0, 1'b1, 32'h0000_2000, 4'b0011,
            32'h1234_5678, 32'h0BAD_F00D, 1'b0, 1'b0);
  endtask

  task automatic test_grant_timeout();
    run_txn("gnt_timeout", TO + 5, 0, 1'b0, 32'h0000_3000, 4'hF,
            32'h0, 32'h1111_1111, 1'b0, 1'b0);
  endtask

  task automatic test_rsp_timeout_late();
    run_txn("rsp_timeout", 0, TO + 1, 1'b0, 32'h0000_4000, 4'hF,
            32'h0, 32'h2222_2222, 1'b0, 1'b0);
  endtask

  task automatic test_slave_err();
    run_txn("slave_err", 1, 2, 1'b0, 32'h0000_4800, 4'hF,
            32'h0, 32'h3C3C_3C3C, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_boundary", TO - 1, TO - 1, 1'b0, 32'h0000_5000,
            4'hF, 32'h0, 32'h5555_AAAA, 1'b0, 1'b1);
    run_txn("b2b_second", 0, 0, 1'b1, 32'h0000_5004, 4'b1100,
            32'hCAFE_0001, 32'h6666_7777, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_rsp();
    s_req = 1'b1;
    s_addr = 32'h0000_6000;
    s_we = 1'b0;
    s_be = 4'hF;
    tick();
    s_req = 1'b0;
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (m_req !== 1'b0 || m_addr !== 32'd0 || m_be !== 4'd0 ||
        s_rvalid !== 1'b0 || s_err !== 1'b0 || s_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid got req=%b addr=%h rv=%b err=%b rd=%h",
               m_req, m_addr, s_rvalid, s_err, s_rdata);
    end
    m_rvalid = 1'b1;
    m_rdata = 32'h7777_8888;
    for (int i = 0; i < 3; i++) begin
      tick();
      m_rvalid = 1'b0;
      checks++;
      if (s_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid stray s_rvalid got %b want 0", s_rvalid);
      end
    end
    run_txn("after_reset", 0, 1, 1'b0, 32'h0000_6004, 4'hF,
            32'h0, 32'h9999_0000, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_txn("random",
              int'($urandom_range(0, TO + 1)),
              int'($urandom_range(0, TO + 2)),
              1'($urandom), $urandom, 4'($urandom),
              $urandom, $urandom, 1'($urandom),
              1'($urandom));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_read_immediate();
    test_write_stall();
    test_grant_timeout();
    test_rsp_timeout_late();
    test_slave_err();
    test_back_to_back();
    test_reset_mid_rsp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
